// File: rtl/svc_uart_pkg.sv
// Shared UART definitions: line FSM states and frame geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package svc_uart_pkg;

  // Line state shared by the RX and TX engines.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/svc_sync_fifo.sv
// Generic synchronous FIFO with a combinational head read.
// Latency: write to rd_data/!empty is 1 cycle.
// Backpressure: a write while full is dropped unless a read happens in the same cycle.
module svc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_rd;
  logic             do_wr;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A read frees the slot in the same cycle, so a write to a full FIFO with a read is kept.
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Storage array: written only, never reset (contents are qualified by count).
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/svc_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, centre-sampling FSM, byte stream out; SVC_UART_RX_FIFO_EN selects FIFO storage.
// Latency: rx_valid rises 1 cycle after the mid-stop sample (pin to rx_s is 2 cycles).
// Backpressure: bytes completing while storage is full (and not popped that cycle) are dropped with an overrun pulse.
module svc_uart_rx
  import svc_uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  logic [1:0]                sync_q;
  logic                      rx_s;
  uart_state_t               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      armed_q, armed_d;
  logic                      fire;
  logic                      push_vld;
  logic                      ferr_set;
  logic                      ovr_set;
  logic                      pop;

  assign rx_s = sync_q[1];
  assign fire = (cnt_q == '0);

  // Two-stage synchroniser for the asynchronous pin; resets to the idle (high) level.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], uart_rx};
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
    end
  end

  // Next-state: half-bit to mid-start, then whole bits to each data centre and the stop centre.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    armed_d  = armed_q;
    push_vld = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        // After a framing error the line may still be low (break); wait for it to go high.
        if (!armed_q) begin
          if (rx_s) armed_d = 1'b1;
        end else if (!rx_s) begin
          cnt_d   = CNT_HALF;
          state_d = START;
        end
      end
      START: begin
        if (!fire) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!rx_s) begin
          cnt_d   = CNT_FULL;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!fire) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          cnt_d   = CNT_FULL;
          if (idx_q == IDX_LAST) state_d = STOP;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      STOP: begin
        if (!fire) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Leave STOP at mid-stop so a start bit directly after the stop bit is seen.
          state_d = IDLE;
          if (rx_s) begin
            push_vld = 1'b1;
          end else begin
            ferr_set = 1'b1;
            armed_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SVC_UART_RX_FIFO_EN
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;

  assign rx_valid = !fifo_empty;
  assign rx_data  = fifo_empty ? 8'h00 : fifo_head;
  assign pop      = rx_valid && rx_ready;
  assign ovr_set  = push_vld && fifo_full && !pop;

  svc_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_vld),
    .wr_data (shift_q),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );
`else
  logic       hold_vld;
  logic [7:0] hold_dat;
  logic       store_ok;

  assign rx_valid = hold_vld;
  assign rx_data  = hold_dat;
  assign pop      = hold_vld && rx_ready;
  assign store_ok = push_vld && (!hold_vld || pop);
  assign ovr_set  = push_vld && hold_vld && !pop;

  // Single holding register; a same-cycle pop makes room for the incoming byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_vld <= 1'b0;
      hold_dat <= 8'h00;
    end else if (store_ok) begin
      hold_vld <= 1'b1;
      hold_dat <= shift_q;
    end else if (pop) begin
      hold_vld <= 1'b0;
    end
  end
`endif

  // Error pulses, one cycle each.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= ovr_set;
    end
  end

endmodule
